sirv_gnrl_dfflr_pipe: RTL and testbench

- Parametrised successor to the general load-enable/reset DFF: a chain of DEPTH register stages, each with valid/ready handshake, programmable data reset value, and bubble collapsing.
- Gives a registered, back-pressurable retiming path between pipeline units, for example between the fetch/decode or writeback paths.
- Adds synchronous flush and an occupancy count, which a single DFF does not have.

---
 rtl/sirv_gnrl_dfflr_pipe.sv | 110 +++++++++++
 tb/tb_sirv_gnrl_dfflr_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sirv_gnrl_dfflr_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : sirv_gnrl_dfflr_pipe                                            |
// | Desc   : DEPTH-stage valid/ready register pipeline with bubble collapse, |
// |          synchronous flush and occupancy count.                          |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module sirv_gnrl_dfflr_pipe #(
  parameter int              DW      = 32,
  parameter int              DEPTH   = 2,
  parameter logic [DW-1:0]   RST_VAL = {DW{1'b0}},
  parameter int              CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [CW-1:0] cnt
);

  logic [DEPTH-1:0] vld;
  logic [DW-1:0]    dat    [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             rdy_acc;
  logic [DEPTH-1:0] ld;
  logic [DW-1:0]    ld_dat [DEPTH];
  logic             xfer_in;
  logic             xfer_out;

  // Ready chain: a stage may take new data when it is empty or everything downstream of it moves.
  // A running accumulator keeps the chain free of self-referencing vector bits.
  always_comb begin
    rdy        = '0;
    rdy_acc    = o_rdy;
    rdy[DEPTH] = o_rdy;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy_acc = ~vld[k] | rdy_acc;
      rdy[k]  = rdy_acc;
    end
  end

  assign i_rdy    = rdy[0] & ~flush & rst_n;
  assign xfer_in  = i_vld & i_rdy;
  assign xfer_out = o_vld & o_rdy;
  assign o_vld    = vld[DEPTH-1];
  assign o_dat    = dat[DEPTH-1];

  // Source of each stage: the upstream handshake for stage 0, the previous stage otherwise.
  always_comb begin
    ld     = '0;
    ld_dat = '{default: '0};
    ld[0]     = xfer_in;
    ld_dat[0] = i_dat;
    for (int k = 1; k < DEPTH; k++) begin
      ld[k]     = vld[k-1];
      ld_dat[k] = dat[k-1];
    end
  end

  // Stage registers: data moves only on a load, a ready stage with no source goes empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dat[k] <= RST_VAL;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          if (ld[k]) begin
            vld[k] <= 1'b1;
            dat[k] <= ld_dat[k];
          end else begin
            vld[k] <= 1'b0;
          end
        end
      end
    end
  end

  // Occupancy: tracks words held, moved by the input and output handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(xfer_in) - CW'(xfer_out);
    end
  end

`ifndef SYNTHESIS
  // Simulation-only consistency: count matches stage valids, controls are known out of reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown({i_vld, o_rdy, flush}));
      assert (cnt == CW'($countones(vld)));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sirv_gnrl_dfflr_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_sirv_gnrl_dfflr_pipe                                         |
// | Desc   : Scoreboard bench driving a DEPTH=4 and a DEPTH=1 pipe from one  |
// |          shared stimulus stream.                                         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_sirv_gnrl_dfflr_pipe;

  localparam logic [31:0] RV0 = 32'hDEADBEEF;
  localparam logic [31:0] RV1 = 32'h0000_1234;

  logic        clk = 1'b0;
  logic        rst_n, flush, i_vld, o_rdy;
  logic [31:0] i_dat;
  logic        i_rdy4, o_vld4, i_rdy1, o_vld1;
  logic [31:0] o_dat4, o_dat1;
  logic [2:0]  cnt4;
  logic [0:0]  cnt1;

  always #5 clk = ~clk;

  sirv_gnrl_dfflr_pipe #(.DW(32), .DEPTH(4), .RST_VAL(RV0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(i_rdy4),
    .i_dat(i_dat), .o_vld(o_vld4), .o_rdy(o_rdy), .o_dat(o_dat4), .cnt(cnt4)
  );

  sirv_gnrl_dfflr_pipe #(.DW(32), .DEPTH(1), .RST_VAL(RV1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(i_rdy1),
    .i_dat(i_dat), .o_vld(o_vld1), .o_rdy(o_rdy), .o_dat(o_dat1), .cnt(cnt1)
  );

  // Reference: each pipe is a FIFO of accepted words; the oldest word is visible
  // DEPTH cycles after it was accepted, and never earlier than the cycle after
  // its predecessor left. Ready = not full or draining, gated by flush/reset.
  typedef struct {
    logic [31:0] d;
    int          acc;
  } word_t;

  word_t       sbq [2][$];
  logic [31:0] last_seen [2];
  int          last_dep  [2];
  logic        exp_ir    [2];
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s depth=%0d cyc=%0d got=%h want=%h", nm, (inst == 0) ? 4 : 1, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs with the reference state and retires words on output handshakes.
  initial begin
    last_seen[0] = RV0;
    last_seen[1] = RV1;
    last_dep[0]  = -100;
    last_dep[1]  = -100;
    exp_ir[0]    = 1'b0;
    exp_ir[1]    = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        int          dep;
        logic        ir, ov, eov;
        logic [31:0] od, cn;
        dep = (i == 0) ? 4 : 1;
        ir  = (i == 0) ? i_rdy4 : i_rdy1;
        ov  = (i == 0) ? o_vld4 : o_vld1;
        od  = (i == 0) ? o_dat4 : o_dat1;
        cn  = (i == 0) ? {29'b0, cnt4} : {31'b0, cnt1};
        exp_ir[i] = rst_n && !flush && (o_rdy || (sbq[i].size() < dep));
        check("i_rdy", i, {31'b0, ir}, {31'b0, exp_ir[i]});
        check("cnt", i, cn, 32'(sbq[i].size()));
        eov = (sbq[i].size() > 0) && (cyc >= sbq[i][0].acc + dep) && (cyc >= last_dep[i] + 1);
        check("o_vld", i, {31'b0, ov}, {31'b0, eov});
        if (eov) begin
          check("o_dat", i, od, sbq[i][0].d);
          last_seen[i] = sbq[i][0].d;
          if (o_rdy) begin
            void'(sbq[i].pop_front());
            last_dep[i] = cyc;
          end
        end else begin
          check("o_dat_hold", i, od, last_seen[i]);
        end
      end
    end
  end

  // One clock of stimulus; records accepted words and applies flush/reset to the reference.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f,
                      input logic rn, output logic acc);
    word_t w;
    @(negedge clk);
    i_vld = v;
    i_dat = d;
    o_rdy = r;
    flush = f;
    rst_n = rn;
    #2;
    for (int i = 0; i < 2; i++) begin
      if (v && exp_ir[i]) begin
        w.d   = d;
        w.acc = cyc;
        sbq[i].push_back(w);
      end
      if (f || !rn) begin
        sbq[i].delete();
        if (!rn) last_seen[i] = (i == 0) ? RV0 : RV1;
      end
    end
    acc = v && exp_ir[0];
  endtask

  // Stimulus: directed scenarios followed by random traffic and a final drain.
  initial begin
    logic a;
    int   k;
    rst_n = 1'b0;
    flush = 1'b0;
    i_vld = 1'b0;
    o_rdy = 1'b0;
    i_dat = '0;
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, a);

    // back-to-back words into a free-running pipe
    for (k = 0; k < 3; k++) step(1'b1, 32'h11 * (k + 1), 1'b1, 1'b0, 1'b1, a);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a);

    // fill under back-pressure, then release
    k = 0;
    repeat (8) begin
      step(1'b1, 32'hA0 + k, 1'b0, 1'b0, 1'b1, a);
      if (a) k++;
    end
    while (k < 6) begin
      step(1'b1, 32'hA0 + k, 1'b1, 1'b0, 1'b1, a);
      if (a) k++;
    end
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a);

    // lone word collapses to the output while stalled, second word queues behind it
    step(1'b1, 32'h5, 1'b0, 1'b0, 1'b1, a);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 32'h6, 1'b0, 1'b0, 1'b1, a);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, a);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a);

    // full pipe flushed with input pending, then resume
    repeat (6) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 32'hF1, 1'b0, 1'b1, 1'b1, a);
    repeat (4) step(1'b1, $urandom, 1'b1, 1'b0, 1'b1, a);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a);

    // reset while holding words with input pending
    repeat (3) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 32'hBAD, 1'b0, 1'b0, 1'b0, a);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a);

    // random traffic with occasional flush and reset
    repeat (400) step(($urandom % 4) != 0, $urandom, ($urandom % 4) != 0,
                      ($urandom % 40) == 0, ($urandom % 100) != 0, a);

    // drain
    k = 0;
    while (((sbq[0].size() > 0) || (sbq[1].size() > 0)) && (k < 50)) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a);
      k++;
    end
    if ((sbq[0].size() > 0) || (sbq[1].size() > 0)) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d/%0d words left want=0", sbq[0].size(), sbq[1].size());
    end
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
